// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op encodings, FSM states and small op-class helpers.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic md_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // Ops whose result is the upper product half or the remainder.
  function automatic logic md_sel_hi(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_MULHU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation of a word pair, either as two
// independent XLEN words or as one 2*XLEN word (wide=1).
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            wide,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic            neg_hi,
  input  logic            neg_lo,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [2*XLEN-1:0] cat;
  logic [2*XLEN-1:0] cat_n;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;

  always_comb begin
    cat   = {hi_i, lo_i};
    cat_n = -cat;
    hi_n  = -hi_i;
    lo_n  = -lo_i;
    if (wide) begin
      {hi_o, lo_o} = neg_hi ? cat_n : cat;
    end else begin
      hi_o = neg_hi ? hi_n : hi_i;
      lo_o = neg_lo ? lo_n : lo_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring
// divide, one bit per cycle, corner cases resolved at issue.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int DW = 2 * XLEN;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  md_op_e          op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  logic            is_div_q;
  logic [XLEN-1:0] fix_hi_in, fix_lo_in;
  logic [XLEN-1:0] fix_hi, fix_lo;
  logic [XLEN-1:0] fix_sel;

  logic [XLEN+1:0] rem_sh, diff;
  logic            q_bit;

  assign op_in = md_op_e'(op);
  assign a_neg = md_a_signed(op_in) & a[XLEN-1];
  assign b_neg = md_b_signed(op_in) & b[XLEN-1];

  muldiv_sign_fix #(.XLEN(XLEN)) u_pre (
    .wide   (1'b0),
    .hi_i   (a),
    .lo_i   (b),
    .neg_hi (a_neg),
    .neg_lo (b_neg),
    .hi_o   (mag_a),
    .lo_o   (mag_b)
  );

  always_comb begin
    div_zero = md_is_div(op_in) && (b == '0);
    div_ovf  = (op_in inside {MD_DIV, MD_REM})
               && (a == SMIN) && (b == ONES);
    if (div_zero) begin
      special_res = md_is_rem(op_in) ? a : ONES;
    end else begin
      special_res = md_is_rem(op_in) ? '0 : SMIN;
    end
  end

  assign is_div_q  = md_is_div(op_q);
  assign fix_hi_in = is_div_q ? rem_q[XLEN-1:0] : acc_q[DW-1:XLEN];
  assign fix_lo_in = is_div_q ? opa_q[XLEN-1:0] : acc_q[XLEN-1:0];

  // Remainder follows the dividend sign; quotient/product the xor.
  muldiv_sign_fix #(.XLEN(XLEN)) u_post (
    .wide   (!is_div_q),
    .hi_i   (fix_hi_in),
    .lo_i   (fix_lo_in),
    .neg_hi (is_div_q ? neg_rem_q : neg_res_q),
    .neg_lo (neg_res_q),
    .hi_o   (fix_hi),
    .lo_o   (fix_lo)
  );

  assign fix_sel = md_sel_hi(op_q) ? fix_hi : fix_lo;

  // Restoring step; the extra top bit carries the trial sign.
  assign rem_sh = {rem_q, opa_q[XLEN-1]};
  assign diff   = rem_sh - {2'b00, opb_q};
  assign q_bit  = !diff[XLEN+1];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    res_d     = res_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d      = op_in;
          cnt_d     = '0;
          acc_d     = '0;
          rem_d     = '0;
          opa_d     = {{XLEN{1'b0}}, mag_a};
          opb_d     = mag_b;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          rem_d = q_bit ? diff[XLEN:0] : rem_sh[XLEN:0];
          opa_d = {opa_q[DW-1:XLEN], opa_q[XLEN-2:0], q_bit};
        end else begin
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        res_d   = fix_sel;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule
